// File: rtl/sram_controller.sv
// SRAM controller for a pipeline MEM stage.
// Each load or store holds the pipeline for a fixed number of SRAM access cycles.
// The transaction then spends one DONE cycle with ready high before the next can start.
// Out-of-range accesses never touch the SRAM; they return zero and pulse addr_err.
module sram_controller #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned SRAM_ADDR_W = 16,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      address,
  input  logic [DATA_W-1:0]      write_data,
  output logic [DATA_W-1:0]      read_data,
  output logic                   ready,
  output logic                   addr_err,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0]      sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [DATA_W-1:0]      sram_dq_in,
  output logic                   sram_we_n
);

  localparam int unsigned       CntW     = 6;
  localparam logic [CntW-1:0]   LastCnt  = CntW'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                 state_q, state_d, state_eff;
  logic [CntW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic                   is_wr_q, is_wr_d;
  logic                   oor_q, oor_d;
  logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0]      dq_out_q, dq_out_d;
  logic                   we_n_q, we_n_d;
  logic                   oe_q, oe_d;
  logic [DATA_W-1:0]      read_data_q, read_data_d;
  logic                   addr_err_q, addr_err_d;

  logic                   req;
  logic                   req_oor;
  logic [ADDR_W-1:0]      offset;
  logic [ADDR_W-1:0]      word_full;

  // Decode the incoming byte address into a word address and range flag.
  always_comb begin
    req       = rd_en | wr_en;
    offset    = address - BaseAddr;
    word_full = offset >> 2;
    // Any word-address bit above the SRAM depth means the access misses the array.
    req_oor   = (address < BaseAddr) || ((word_full >> SRAM_ADDR_W) != '0);
    cnt_inc   = cnt_q + CntW'(1);
  end

  // Pipeline stall: while in reset the FSM is treated as idle.
  always_comb begin
    state_eff = rst ? state_q : StIdle;
    ready     = !(((state_eff == StIdle) && req) || (state_eff == StAccess));
  end

  // Next-state logic. SRAM strobes are registered, so they are computed
  // one cycle ahead of the ACCESS cycle they belong to.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    oor_d       = oor_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    we_n_d      = 1'b1;
    oe_d        = 1'b0;
    read_data_d = read_data_q;
    addr_err_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d     = StAccess;
          cnt_d       = '0;
          // Simultaneous rd_en and wr_en resolve to a write.
          is_wr_d     = wr_en;
          oor_d       = req_oor;
          sram_addr_d = word_full[SRAM_ADDR_W-1:0];
          dq_out_d    = wr_en ? write_data : dq_out_q;
          oe_d        = wr_en && !req_oor;
          // The last ACCESS cycle releases the strobe, so a one-cycle access never asserts it.
          we_n_d      = !(wr_en && !req_oor && (LastCnt != '0));
        end
      end
      StAccess: begin
        if (cnt_q == LastCnt) begin
          state_d    = StDone;
          addr_err_d = oor_q;
          if (oor_q) begin
            read_data_d = '0;
          end else if (!is_wr_q) begin
            read_data_d = sram_dq_in;
          end
        end else begin
          cnt_d  = cnt_inc;
          oe_d   = is_wr_q && !oor_q;
          we_n_d = !(is_wr_q && !oor_q && (cnt_inc != LastCnt));
        end
      end
      StDone: begin
        // Requests still held here belong to the finished transaction.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      oor_q       <= 1'b0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      we_n_q      <= 1'b1;
      oe_q        <= 1'b0;
      read_data_q <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      oor_q       <= oor_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      we_n_q      <= we_n_d;
      oe_q        <= oe_d;
      read_data_q <= read_data_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign read_data   = read_data_q;
  assign addr_err    = addr_err_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;

endmodule
